// File: rtl/trace_pkg.sv
// Shared widths, field layout and packing helper for writeback trace entries.
package trace_pkg;

    localparam int PC_W    = 32;
    localparam int RA_W    = 5;
    localparam int RD_W    = 32;
    localparam int SEQ_W   = 16;
    localparam int TRACE_W = PC_W + RA_W + RD_W + SEQ_W;

    // Entry layout, LSB first: seq, wdata, addr, pc
    localparam int SEQ_LSB = 0;
    localparam int RD_LSB  = SEQ_LSB + SEQ_W;
    localparam int RA_LSB  = RD_LSB + RD_W;
    localparam int PC_LSB  = RA_LSB + RA_W;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    function automatic logic [TRACE_W-1:0] pack_entry(
        input logic [PC_W-1:0]  pc,
        input logic [RA_W-1:0]  addr,
        input logic [RD_W-1:0]  wdata,
        input logic [SEQ_W-1:0] seq
    );
        logic [TRACE_W-1:0] e;
        e = '0;
        e[PC_LSB  +: PC_W]  = pc;
        e[RA_LSB  +: RA_W]  = addr;
        e[RD_LSB  +: RD_W]  = wdata;
        e[SEQ_LSB +: SEQ_W] = seq;
        return e;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [TRACE_W-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [TRACE_W-1:0]       rdata
);

    logic [TRACE_W-1:0] mem [DEPTH];

    // No reset: contents are only meaningful below the owner's count
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Captures register-file writeback events into a FWFT FIFO with sequence tags
// and sticky drop accounting when the reader falls behind.
module wb_trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter bit FILTER_R0 = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            wb_pc,
    input  logic                   wb_rf_wen,
    input  logic [4:0]             wb_rf_addr,
    input  logic [31:0]            wb_rf_wdata,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [31:0]            rd_pc,
    output logic [4:0]             rd_addr,
    output logic [31:0]            rd_wdata,
    output logic [15:0]            rd_seq,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [15:0]            drop_cnt,
    input  logic                   clr_ovf
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [SEQ_W-1:0]   seq;
    logic [TRACE_W-1:0] head;
    logic               wb_event;
    logic               push;
    logic               pop;
    logic               drop;

    assign wb_event = wb_rf_wen && ((wb_rf_addr != 5'd0) || !FILTER_R0);
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot a full FIFO needs
    assign push     = wb_event && ((count != FULL_COUNT) || pop);
    assign drop     = wb_event && !push;

    trace_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (pack_entry(wb_pc, wb_rf_addr, wb_rf_wdata, seq)),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            seq    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (wb_event) seq <= seq + 16'd1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Clear is applied before a coincident drop is counted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf)                  drop_cnt <= 16'd1;
            else if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 16'd1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    always_comb begin
        rd_valid = (count != '0);
        rd_pc    = '0;
        rd_addr  = '0;
        rd_wdata = '0;
        rd_seq   = '0;
        if (rd_valid) begin
            rd_pc    = head[PC_LSB  +: PC_W];
            rd_addr  = head[RA_LSB  +: RA_W];
            rd_wdata = head[RD_LSB  +: RD_W];
            rd_seq   = head[SEQ_LSB +: SEQ_W];
        end
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench for wb_trace_fifo: directed writeback events, a monitor
// checks every popped entry against the queue of expected entries.
module tb_wb_trace_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_pc;
    logic        wb_rf_wen;
    logic [4:0]  wb_rf_addr;
    logic [31:0] wb_rf_wdata;
    logic        rd_ready;
    logic        clr_ovf;

    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [15:0] rd_seq;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    logic        nf_valid;
    logic [31:0] nf_pc;
    logic [4:0]  nf_addr;
    logic [31:0] nf_wdata;
    logic [15:0] nf_seq;
    logic [4:0]  nf_count;
    logic        nf_overflow;
    logic [15:0] nf_drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [84:0] exp_q[$];

    wb_trace_fifo #(.DEPTH(16), .FILTER_R0(1'b1)) dut (
        .clk(clk), .reset(reset), .wb_pc(wb_pc), .wb_rf_wen(wb_rf_wen),
        .wb_rf_addr(wb_rf_addr), .wb_rf_wdata(wb_rf_wdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
        .rd_addr(rd_addr), .rd_wdata(rd_wdata), .rd_seq(rd_seq),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt),
        .clr_ovf(clr_ovf)
    );

    wb_trace_fifo #(.DEPTH(16), .FILTER_R0(1'b0)) dut_nf (
        .clk(clk), .reset(reset), .wb_pc(wb_pc), .wb_rf_wen(wb_rf_wen),
        .wb_rf_addr(wb_rf_addr), .wb_rf_wdata(wb_rf_wdata),
        .rd_valid(nf_valid), .rd_ready(rd_ready), .rd_pc(nf_pc),
        .rd_addr(nf_addr), .rd_wdata(nf_wdata), .rd_seq(nf_seq),
        .count(nf_count), .overflow(nf_overflow), .drop_cnt(nf_drop_cnt),
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pc_of(input logic [31:0] data);
        return 32'h8000_0000 + (data << 2);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        else
            n_pass++;
    endtask

    task automatic applyStimulus(input logic wen, input logic [4:0] addr,
                                 input logic [31:0] data, input logic rdy,
                                 input logic clr);
        wb_rf_wen   = wen;
        wb_rf_addr  = addr;
        wb_rf_wdata = data;
        wb_pc       = pc_of(data);
        rd_ready    = rdy;
        clr_ovf     = clr;
        @(posedge clk);
        #1;
        wb_rf_wen = 1'b0;
        rd_ready  = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    task automatic expectEntry(input logic [4:0] addr, input logic [31:0] data,
                               input logic [15:0] seq);
        exp_q.push_back({pc_of(data), addr, data, seq});
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, rdy, 1'b0);
    endtask

    // Reset pulse entirely between clock edges
    task automatic pulseReset();
        #2 reset = 1'b1;
        #4 reset = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: every handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (rd_valid && rd_ready) begin
            logic [84:0] exp_e;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL pop_unexpected: got seq %0d, expected no entry", rd_seq);
            end else begin
                exp_e = exp_q.pop_front();
                if ({rd_pc, rd_addr, rd_wdata, rd_seq} !== exp_e)
                    $display("[TB] FAIL pop_entry: got pc=%h addr=%0d data=%h seq=%0d, expected pc=%h addr=%0d data=%h seq=%0d",
                             rd_pc, rd_addr, rd_wdata, rd_seq,
                             exp_e[84:53], exp_e[52:48], exp_e[47:16], exp_e[15:0]);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #200000;
        n_checks++;
        $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1; wb_rf_wen = 1'b0; wb_rf_addr = '0; wb_rf_wdata = '0;
        wb_pc = '0; rd_ready = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("reset_count",    32'(count),    32'd0);
        checkOutput("reset_valid",    32'(rd_valid), 32'd0);
        checkOutput("reset_pc",       rd_pc,         32'd0);
        checkOutput("reset_seq",      32'(rd_seq),   32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_drop",     32'(drop_cnt), 32'd0);

        // Basic capture and in-order drain
        expectEntry(5'd8,  32'h11, 16'd0);
        expectEntry(5'd9,  32'h22, 16'd1);
        expectEntry(5'd10, 32'h33, 16'd2);
        applyStimulus(1'b1, 5'd8,  32'h11, 1'b0, 1'b0);
        checkOutput("first_latency_valid", 32'(rd_valid), 32'd1);
        applyStimulus(1'b1, 5'd9,  32'h22, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd10, 32'h33, 1'b0, 1'b0);
        checkOutput("basic_count", 32'(count),   32'd3);
        checkOutput("basic_addr",  32'(rd_addr), 32'd8);
        checkOutput("basic_data",  rd_wdata,     32'h11);
        checkOutput("basic_seq",   32'(rd_seq),  32'd0);
        idle(1'b1, 3);
        checkOutput("basic_empty_valid", 32'(rd_valid), 32'd0);
        checkOutput("basic_empty_addr",  32'(rd_addr),  32'd0);

        // Register-0 filter: filtered vs unfiltered instance
        pulseReset();
        applyStimulus(1'b1, 5'd0, 32'h44, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd5, 32'h55, 1'b0, 1'b0);
        checkOutput("r0_count",    32'(count),    32'd1);
        checkOutput("r0_addr",     32'(rd_addr),  32'd5);
        checkOutput("r0_seq",      32'(rd_seq),   32'd0);
        checkOutput("nf_count",    32'(nf_count), 32'd2);
        checkOutput("nf_valid",    32'(nf_valid), 32'd1);
        checkOutput("nf_addr",     32'(nf_addr),  32'd0);
        checkOutput("nf_data",     nf_wdata,      32'h44);
        checkOutput("nf_pc",       nf_pc,         32'h8000_0110);
        checkOutput("nf_seq",      32'(nf_seq),   32'd0);
        checkOutput("nf_overflow", 32'(nf_overflow), 32'd0);
        checkOutput("nf_drop",     32'(nf_drop_cnt), 32'd0);
        expectEntry(5'd5, 32'h55, 16'd0);
        idle(1'b1, 1);
        checkOutput("r0_drained", 32'(count), 32'd0);

        // Overflow: 20 events into 16 slots
        pulseReset();
        for (int i = 0; i < 20; i++) begin
            if (i < 16) expectEntry(5'((i % 31) + 1), 32'h100 + 32'(i), 16'(i));
            applyStimulus(1'b1, 5'((i % 31) + 1), 32'h100 + 32'(i), 1'b0, 1'b0);
        end
        checkOutput("ovf_count", 32'(count),    32'd16);
        checkOutput("ovf_flag",  32'(overflow), 32'd1);
        checkOutput("ovf_drops", 32'(drop_cnt), 32'd4);
        idle(1'b1, 16);
        checkOutput("ovf_drained", 32'(count), 32'd0);
        expectEntry(5'd3, 32'h999, 16'd20);
        applyStimulus(1'b1, 5'd3, 32'h999, 1'b0, 1'b0);
        checkOutput("ovf_next_seq", 32'(rd_seq), 32'd20);
        idle(1'b1, 1);

        // Full with simultaneous event and pop
        for (int i = 0; i < 16; i++) begin
            expectEntry(5'd4, 32'h200 + 32'(i), 16'(21 + i));
            applyStimulus(1'b1, 5'd4, 32'h200 + 32'(i), 1'b0, 1'b0);
        end
        expectEntry(5'd7, 32'hABC, 16'd37);
        applyStimulus(1'b1, 5'd7, 32'hABC, 1'b1, 1'b0);
        checkOutput("fullpp_count", 32'(count),    32'd16);
        checkOutput("fullpp_drops", 32'(drop_cnt), 32'd4);
        idle(1'b1, 16);
        checkOutput("fullpp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Clear alone, then clear coinciding with a drop
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("clr_flag",  32'(overflow), 32'd0);
        checkOutput("clr_drops", 32'(drop_cnt), 32'd0);
        for (int i = 0; i < 19; i++) begin
            if (i < 16) expectEntry(5'd6, 32'h300 + 32'(i), 16'(38 + i));
            applyStimulus(1'b1, 5'd6, 32'h300 + 32'(i), 1'b0, 1'b0);
        end
        checkOutput("cd_pre_drops", 32'(drop_cnt), 32'd3);
        applyStimulus(1'b1, 5'd6, 32'h3FF, 1'b0, 1'b1);
        checkOutput("cd_flag",  32'(overflow), 32'd1);
        checkOutput("cd_drops", 32'(drop_cnt), 32'd1);
        checkOutput("cd_count", 32'(count),    32'd16);

        // Asynchronous reset with seven entries stored
        idle(1'b1, 9);
        checkOutput("ar_pre_count", 32'(count), 32'd7);
        #2 reset = 1'b1;
        #1;
        checkOutput("ar_valid", 32'(rd_valid), 32'd0);
        checkOutput("ar_count", 32'(count),    32'd0);
        exp_q.delete();
        #2 reset = 1'b0;
        expectEntry(5'd12, 32'h777, 16'd0);
        applyStimulus(1'b1, 5'd12, 32'h777, 1'b0, 1'b0);
        checkOutput("ar_seq", 32'(rd_seq), 32'd0);
        idle(1'b1, 1);
        checkOutput("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
